// File: rtl/debug_stream_ctrl_pkg.sv
// Shared command codes, controller state encoding and sizing helpers for the
// debug stream controller and its byte serializer.
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_RST  = 8'h72;

    // Bytes in one word at the default 32-bit word width.
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RUN       = 4'd1,
        STEP      = 4'd2,
        RSTDP     = 4'd3,
        LATCH     = 4'd4,
        SEND_CNT  = 4'd5,
        SEND_SNAP = 4'd6,
        MEM_REQ   = 4'd7,
        SEND_MEM  = 4'd8
    } state_t;

    function automatic int bytes_of(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/debug_stream_ctrl_byte_serializer.sv
// Sends the top nbytes of a left-aligned word MSB first over a
// tx_start/tx_done byte handshake, then pulses word_done.
module byte_serializer #(
    parameter int W    = 32,
    parameter int NB_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [W-1:0]    word,
    input  logic [NB_W-1:0] nbytes,
    input  logic            tx_done,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    output logic            word_done,
    output logic            busy
);

    typedef enum logic {S_IDLE, S_WAIT} ser_state_t;

    ser_state_t      state_q;
    logic [W-1:0]    shift_q;
    logic [NB_W-1:0] left_q;
    logic            tx_start_q;
    logic            word_done_q;

    // Handshake: tx_start pulses one cycle while tx_data is valid; tx_data
    // stays put until tx_done, which is only honoured in S_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            left_q      <= '0;
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        shift_q    <= word;
                        left_q     <= nbytes - NB_W'(1);
                        tx_start_q <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (left_q == '0) begin
                            word_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            shift_q    <= shift_q << 8;
                            left_q     <= left_q - NB_W'(1);
                            tx_start_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data   = shift_q[W-1 -: 8];
    assign tx_start  = tx_start_q;
    assign word_done = word_done_q;
    assign busy      = (state_q == S_WAIT);

endmodule

// File: rtl/debug_stream_ctrl.sv
// Command-driven debug controller: gates the datapath in run/step modes and,
// on halt, streams cycle count, latched snapshot and a data RAM window.
module debug_stream_ctrl
    import debug_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_WORDS = 16,
    parameter int CNT_W     = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_pop,
    output logic [7:0]                  tx_data,
    output logic                        tx_start,
    input  logic                        tx_done,
    input  logic                        eop,
    input  logic [NUM_WORDS*WORD_W-1:0] snap_in,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [WORD_W-1:0]           mem_rdata,
    output logic                        mem_src,
    output logic                        dp_enable,
    output logic                        dp_reset,
    output logic                        idle,
    output logic                        halted,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [3:0]                  dbg_state
);

    localparam int SER_W     = (WORD_W > CNT_W) ? WORD_W : CNT_W;
    localparam int NB_W      = $clog2(SER_W / 8 + 1);
    localparam int MAX_WORDS = (NUM_WORDS > MEM_WORDS) ? NUM_WORDS : MEM_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS + 1);
    localparam int LAT_W     = $clog2(MEM_LAT + 1);
    localparam logic [NB_W-1:0] CNT_NB  = NB_W'(bytes_of(CNT_W));
    localparam logic [NB_W-1:0] WORD_NB = NB_W'(bytes_of(WORD_W));

    state_t                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          halted_q;
    logic [NUM_WORDS*WORD_W-1:0]   snap_q;
    logic [IDX_W-1:0]              idx_q;
    logic [LAT_W-1:0]              lat_q;
    logic [ADDR_W-1:0]             mem_addr_q;
    logic                          mem_src_q;
    logic                          dp_enable_q;
    logic                          dp_reset_q;
    logic                          ser_load_q;
    logic [SER_W-1:0]              ser_word_q;
    logic [NB_W-1:0]               ser_nb_q;
    logic                          word_done;
    logic                          ser_busy;

    // The serializer always sends from the MSB end, so every field is left-aligned.
    function automatic logic [SER_W-1:0] align_word(input logic [WORD_W-1:0] w);
        return SER_W'(w) << (SER_W - WORD_W);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            snap_q      <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_src_q   <= 1'b0;
            dp_enable_q <= 1'b0;
            dp_reset_q  <= 1'b0;
            ser_load_q  <= 1'b0;
            ser_word_q  <= '0;
            ser_nb_q    <= '0;
        end else begin
            ser_load_q <= 1'b0;
            if (dp_enable_q && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RUN:  if (!halted_q) begin
                                          state_q     <= RUN;
                                          dp_enable_q <= 1'b1;
                                      end
                            CMD_STEP: if (!halted_q) begin
                                          state_q     <= STEP;
                                          dp_enable_q <= 1'b1;
                                      end
                            CMD_RST:  begin
                                          state_q    <= RSTDP;
                                          dp_reset_q <= 1'b1;
                                      end
                            default:  ;
                        endcase
                    end
                end
                RUN: begin
                    if (eop) begin
                        dp_enable_q <= 1'b0;
                        halted_q    <= 1'b1;
                        state_q     <= LATCH;
                    end
                end
                STEP: begin
                    dp_enable_q <= 1'b0;
                    halted_q    <= eop;
                    state_q     <= LATCH;
                end
                RSTDP: begin
                    dp_reset_q <= 1'b0;
                    cnt_q      <= '0;
                    halted_q   <= 1'b0;
                    state_q    <= IDLE;
                end
                LATCH: begin
                    snap_q     <= snap_in;
                    idx_q      <= '0;
                    ser_word_q <= SER_W'(cnt_q) << (SER_W - CNT_W);
                    ser_nb_q   <= CNT_NB;
                    ser_load_q <= 1'b1;
                    state_q    <= SEND_CNT;
                end
                SEND_CNT: begin
                    if (word_done) begin
                        ser_word_q <= align_word(snap_q[0 +: WORD_W]);
                        ser_nb_q   <= WORD_NB;
                        ser_load_q <= 1'b1;
                        state_q    <= SEND_SNAP;
                    end
                end
                SEND_SNAP: begin
                    if (word_done) begin
                        if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                            idx_q      <= '0;
                            lat_q      <= '0;
                            mem_addr_q <= '0;
                            mem_src_q  <= 1'b1;
                            state_q    <= MEM_REQ;
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            ser_word_q <= align_word(snap_q[(int'(idx_q) + 1) * WORD_W +: WORD_W]);
                            ser_load_q <= 1'b1;
                        end
                    end
                end
                MEM_REQ: begin
                    // mem_addr has been stable for MEM_LAT cycles when lat_q hits MEM_LAT.
                    if (lat_q == LAT_W'(MEM_LAT)) begin
                        ser_word_q <= align_word(mem_rdata);
                        ser_nb_q   <= WORD_NB;
                        ser_load_q <= 1'b1;
                        state_q    <= SEND_MEM;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                SEND_MEM: begin
                    if (word_done) begin
                        if (idx_q == IDX_W'(MEM_WORDS - 1)) begin
                            mem_src_q  <= 1'b0;
                            mem_addr_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            mem_addr_q <= ADDR_W'(idx_q + IDX_W'(1));
                            lat_q      <= '0;
                            state_q    <= MEM_REQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    byte_serializer #(
        .W    (SER_W),
        .NB_W (NB_W)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load_q),
        .word      (ser_word_q),
        .nbytes    (ser_nb_q),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .word_done (word_done),
        .busy      (ser_busy)
    );

    assign rx_pop      = (state_q == IDLE) && rx_valid;
    assign idle        = (state_q == IDLE);
    assign halted      = halted_q;
    assign cycle_count = cnt_q;
    assign mem_addr    = mem_addr_q;
    assign mem_src     = mem_src_q;
    assign dp_enable   = dp_enable_q;
    assign dp_reset    = dp_reset_q;
    assign dbg_state   = state_q;

endmodule
